multi_channel_capture: RTL and testbench

MULTI_CHANNEL_CAPTURE -- requirements
Module: multi_channel_capture

---
 rtl/multi_channel_capture.sv | 185 ++++++++++++++++++
 tb/tb_multi_channel_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_capture.sv
// Multi-channel ADC capture with pre-trigger history.
// Lockstep storage per channel, channel-major readout over valid/ready.
module multi_channel_capture #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [NUM_CH-1:0]        trig_mask,
  input  logic                     arm,
  input  logic                     abort,
  output logic [DATA_W-1:0]        out_data,
  output logic [CW-1:0]            out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [CW-1:0]            trig_ch,
  output logic                     done,
  output logic                     overrun
);

  localparam int AW     = $clog2(DEPTH);
  localparam int TOTAL  = NUM_CH * DEPTH;
  localparam int BW     = $clog2(TOTAL) + 1;
  localparam int PRE_L  = PRE_TRIG - 1;
  localparam int POST_L = DEPTH - PRE_TRIG - 1;
  localparam int BEAT_L = TOTAL - 1;

  localparam logic [AW:0]   PRE_LAST  = PRE_L[AW:0];
  localparam logic [AW:0]   POST_LAST = POST_L[AW:0];
  localparam logic [AW-1:0] PRE_OFF   = PRE_TRIG[AW-1:0];
  localparam logic [BW-1:0] TOTAL_B   = TOTAL[BW-1:0];
  localparam logic [BW-1:0] BEAT_LAST = BEAT_L[BW-1:0];

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;

  logic [2:0]        state;
  logic [AW-1:0]     wp;
  logic [AW-1:0]     base;
  logic [AW:0]       cnt;
  logic [BW-1:0]     issued;
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

  logic              hit;
  logic [CW-1:0]     hit_ch;
  logic              wr_en;
  logic [CW-1:0]     rd_ch;
  logic [AW-1:0]     rd_addr;
  logic              fire;
  logic              fire_last;
  logic              load;

  // Trigger qualify: lowest-index enabled channel at or above threshold
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (trig_mask[k] &&
          sample_in[k*DATA_W +: DATA_W] >= threshold) begin
        hit    = 1'b1;
        hit_ch = CW'(k);
      end
    end
  end

  assign wr_en = sample_valid &&
                 (state == S_FILL || state == S_ARMED ||
                  state == S_POST);

  assign rd_ch     = CW'(issued >> AW);
  assign rd_addr   = base + issued[AW-1:0];
  assign fire      = out_valid && out_ready;
  assign fire_last = fire && out_last;
  assign load      = (state == S_READOUT) &&
                     (!out_valid || out_ready) &&
                     (issued < TOTAL_B);

  assign busy = (state != S_IDLE);
  assign done = fire_last && !abort && !reset;

  // Sample storage: all channels written together at wp
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mem[k][wp] <= sample_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // Capture FSM, write pointer and readout output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wp        <= '0;
      base      <= '0;
      cnt       <= '0;
      issued    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      trig_ch   <= '0;
      overrun   <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      cnt       <= '0;
      issued    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            state   <= S_FILL;
            cnt     <= '0;
            overrun <= 1'b0;
            trig_ch <= '0;
          end
        end
        S_FILL: begin
          if (sample_valid) begin
            wp <= wp + 1'b1;
            if (cnt == PRE_LAST) begin
              state <= S_ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (sample_valid) begin
            wp <= wp + 1'b1;
            if (hit) begin
              trig_ch <= hit_ch;
              base    <= wp - PRE_OFF;
              cnt     <= {{AW{1'b0}}, 1'b1};
              issued  <= '0;
              state   <= (POST_LAST == '0) ? S_READOUT : S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid) begin
            wp  <= wp + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == POST_LAST) begin
              state  <= S_READOUT;
              issued <= '0;
            end
          end
        end
        S_READOUT: begin
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          if (fire_last) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ch][rd_addr];
            out_ch    <= rd_ch;
            out_last  <= (issued == BEAT_LAST);
            issued    <= issued + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_capture.sv
// Directed bench for multi_channel_capture.
// Table of capture scenarios plus abort/reset sequences.
module tb_multi_channel_capture;

  localparam int NC = 2;
  localparam int DW = 10;
  localparam int DP = 16;
  localparam int PT = 4;
  localparam int CW = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] sample_in;
  logic             sample_valid;
  logic [DW-1:0]    threshold;
  logic [NC-1:0]    trig_mask;
  logic             arm;
  logic             abort;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_ch;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [CW-1:0]    trig_ch;
  logic             done;
  logic             overrun;

  multi_channel_capture #(
    .NUM_CH(NC), .DATA_W(DW), .DEPTH(DP), .PRE_TRIG(PT)
  ) dut (
    .clk(clk), .reset(reset),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .threshold(threshold), .trig_mask(trig_mask),
    .arm(arm), .abort(abort),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy),
    .trig_ch(trig_ch), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ch0 = base0 + step0*n, ch1 = 0; at spike_n ch1 = s1
  // and ch0 = s0 when s0 >= 0.
  typedef struct {
    int         base0;
    int         step0;
    int         spike_n;
    int         s0;
    int         s1;
    logic [1:0] mask;
    int         exp_n;
    int         exp_ch;
    bit         rnd;
    bit         inj;
  } vec_t;

  vec_t vt[7];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [DW-1:0] gen(vec_t v, int ch, int n);
    int x;
    if (ch == 0)
      x = (n == v.spike_n && v.s0 >= 0) ? v.s0 : v.base0 + v.step0 * n;
    else
      x = (n == v.spike_n) ? v.s1 : 0;
    return x[DW-1:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic feed(vec_t v, int n_last);
    for (int n = 0; n <= n_last; n++) begin
      if (n % 3 == 2) @(negedge clk);
      sample_in    = {gen(v, 1, n), gen(v, 0, n)};
      sample_valid = 1'b1;
      arm          = (n == 2);
      @(negedge clk);
      sample_valid = 1'b0;
      arm          = 1'b0;
    end
  endtask

  task automatic collect(vec_t v, int lim, output int beats, output int dn);
    int             cyc;
    int             ch;
    int             n;
    bit             stalled;
    bit             injected;
    logic [DW+CW:0] held;
    cyc = 0; stalled = 0; injected = 0; held = '0;
    beats = 0; dn = 0;
    while (beats < lim && cyc < 3000) begin
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.inj && beats == 5 && !injected) begin
        sample_valid = 1'b1;
        sample_in    = '1;
        injected     = 1;
      end
      #1;
      if (stalled)
        check("stall_hold", {out_valid, out_ch, out_data, out_last},
              {1'b1, held});
      if (out_valid && out_ready) begin
        ch = beats / DP;
        n  = v.exp_n - PT + beats % DP;
        check($sformatf("beat%0d", beats),
              {out_ch, out_data, out_last},
              {ch[CW-1:0], gen(v, ch, n), beats == NC*DP-1});
        beats++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held    = {out_ch, out_data, out_last};
      end
      if (done) dn++;
      @(negedge clk);
      cyc++;
      sample_valid = 1'b0;
    end
    out_ready = 1'b1;
    if (beats < lim) check("beat_timeout", beats, lim);
  endtask

  task automatic run(vec_t v, string tag);
    int beats;
    int dn;
    trig_mask = v.mask;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    feed(v, v.exp_n + DP - PT - 1);
    collect(v, NC*DP, beats, dn);
    #1;
    check({tag, "_done_cnt"}, dn, 1);
    check({tag, "_idle"}, {busy, out_valid, done}, 3'b000);
    check({tag, "_trig_ch"}, trig_ch, v.exp_ch);
    check({tag, "_overrun"}, overrun, v.inj);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int  beats;
    int  dn;
    bit  seen;
    vt[0] = '{0,    1,  20, -1, 600,  2'b11, 20, 1, 0, 0};
    vt[1] = '{700,  1,  -1, -1, 0,    2'b11, 4,  0, 0, 0};
    vt[2] = '{0,    1,  9,  600, 600, 2'b11, 9,  0, 1, 0};
    vt[3] = '{500,  1,  -1, -1, 0,    2'b01, 12, 0, 0, 1};
    vt[4] = '{1023, 0,  10, -1, 512,  2'b10, 10, 1, 1, 0};
    vt[5] = '{505,  1,  6,  -1, 1000, 2'b01, 7,  0, 0, 0};
    vt[6] = '{300,  20, 2,  -1, 900,  2'b11, 11, 0, 0, 0};

    reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
    threshold = 10'd512; trig_mask = 2'b11;
    arm = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state",
          {busy, out_valid, out_last, done, overrun,
           trig_ch, out_ch, out_data}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run(vt[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    trig_mask = 2'b11;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    feed(vt[0], 31);
    collect(vt[0], 10, beats, dn);
    abort = 1'b1;
    #1;
    check("abort_no_done", done, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_idle", {busy, out_valid}, 2'b00);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done || out_valid) seen = 1;
    end
    check("abort_quiet", seen, 0);

    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    #1;
    check("arm_abort_busy", busy, 1'b0);

    @(negedge clk);
    trig_mask = 2'b11;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    feed(vt[0], 23);
    #1;
    check("pre_rst_state", {busy, trig_ch}, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_state",
          {busy, out_valid, out_last, done, overrun,
           trig_ch, out_ch, out_data}, '0);
    reset = 1'b0;
    @(negedge clk);
    run(vt[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
